// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// boot address and sequential PC step.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
  localparam int          PC_INC       = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: single-outstanding SRAM-like fetch, one-entry
// instruction buffer toward IF/ID, and branch redirect with in-flight cancel.
//
// state | meaning
// BOOT  | one idle cycle after reset release
// REQ   | inst_sram_req high on fetch_pc, waiting for addr_ok
// WAIT  | one access outstanding, waiting for data_ok
// HOLD  | instruction buffered, o_if_valid high until taken or redirected
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            inst_sram_req,
  output logic [PC_W-1:0] inst_sram_addr,
  input  logic            inst_sram_addr_ok,
  input  logic            inst_sram_data_ok,
  input  logic [31:0]     inst_sram_rdata,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_inst
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
  logic            cancel, cancel_nxt;
  logic            load_inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      cancel   <= 1'b0;
      if_pc    <= RESET_PC;
      if_inst  <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      cancel   <= cancel_nxt;
      if (load_inst) begin
        if_pc   <= fetch_pc;
        if_inst <= inst_sram_rdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    cancel_nxt   = cancel;
    load_inst    = 1'b0;
    unique case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        // A same-cycle handshake commits the old address, so it must be cancelled.
        if (inst_sram_addr_ok) begin
          state_nxt = WAIT;
          if (br_taken) begin
            cancel_nxt   = 1'b1;
            fetch_pc_nxt = br_target;
          end
        end else if (br_taken) begin
          fetch_pc_nxt = br_target;
        end
      end
      WAIT: begin
        if (inst_sram_data_ok) begin
          state_nxt  = REQ;
          cancel_nxt = 1'b0;
          if (br_taken) begin
            fetch_pc_nxt = br_target;
          end else if (!cancel) begin
            state_nxt = HOLD;
            load_inst = 1'b1;
          end
        end else if (br_taken) begin
          cancel_nxt   = 1'b1;
          fetch_pc_nxt = br_target;
        end
      end
      HOLD: begin
        if (br_taken) begin
          state_nxt    = REQ;
          fetch_pc_nxt = br_target;
        end else if (i_if_ready) begin
          state_nxt    = REQ;
          fetch_pc_nxt = fetch_pc + PC_W'(PC_INC);
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign inst_sram_req  = (state == REQ);
  assign inst_sram_addr = fetch_pc;
  assign o_if_valid     = (state == HOLD);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an SRAM responder and a PC-stream
// reference model checked every cycle on the falling edge.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;
  logic        o_if_valid;
  logic        i_if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  fetch_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .o_if_valid        (o_if_valid),
    .i_if_ready        (i_if_ready),
    .if_pc             (if_pc),
    .if_inst           (if_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;

  // reference model: exp_pc is the address the next useful instruction must come from
  logic [31:0] exp_pc = RST_PC;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          dly = 0;
  logic        prev_valid = 1'b0, prev_xfer = 1'b0, prev_br = 1'b0;

  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] xfer_pc[$];
  int          xfer_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_acc(input int i);
    return (acc_addr.size() > i) ? acc_addr[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] get_xfer(input int i);
    return (xfer_pc.size() > i) ? xfer_pc[i] : 32'hxxxxxxxx;
  endfunction

  function automatic int xfer_gap(input int i);
    return (xfer_cyc.size() > i) ? xfer_cyc[i] - xfer_cyc[i-1] : -1;
  endfunction

  function automatic int acc_gap(input int i);
    return (acc_cyc.size() > i) ? acc_cyc[i] - acc_cyc[i-1] : -1;
  endfunction

  // SRAM responder, per-cycle compare and model update
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_pc = RST_PC;
      pend = 1'b0;
      inst_sram_data_ok = 1'b0;
      prev_valid = 1'b0;
      prev_xfer = 1'b0;
      prev_br = 1'b0;
      continue;
    end
    if (pend && dly == 0) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_word(pend_addr);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'hDEADBEEF;
    end
    if (inst_sram_req) begin
      chk("req_addr", inst_sram_addr, exp_pc);
      chk("req_while_outstanding", 32'(pend), 32'd0);
      chk("req_with_valid", 32'(o_if_valid), 32'd0);
    end
    if (o_if_valid) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_inst", if_inst, mem_word(if_pc));
    end
    if (prev_valid)
      chk("valid_hold", 32'(o_if_valid), 32'(!(prev_xfer || prev_br)));
    prev_valid = o_if_valid;
    prev_xfer  = o_if_valid && i_if_ready;
    prev_br    = br_taken;
    if (inst_sram_req && inst_sram_addr_ok) begin
      acc_addr.push_back(inst_sram_addr);
      acc_cyc.push_back(cyc);
      pend = 1'b1;
      pend_addr = inst_sram_addr;
      dly = mem_lat - 1;
    end else if (inst_sram_data_ok) begin
      pend = 1'b0;
    end else if (pend) begin
      dly--;
    end
    if (o_if_valid && i_if_ready) begin
      xfer_pc.push_back(if_pc);
      xfer_cyc.push_back(cyc);
    end
    if (br_taken) exp_pc = br_target;
    else if (o_if_valid && i_if_ready) exp_pc = exp_pc + 32'd4;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    br_taken = 1'b0;
    inst_sram_addr_ok = 1'b0;
    i_if_ready = 1'b0;
    tick(2);
    acc_addr.delete();
    acc_cyc.delete();
    xfer_pc.delete();
    xfer_cyc.delete();
    rst = 1'b0;
  endtask

  task automatic pulse_br(input logic [31:0] t);
    br_taken = 1'b1;
    br_target = t;
    tick(1);
    br_taken = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input string name);
    int k = 0;
    while (xfer_pc.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    chk({name, "_xfer_timeout"}, 32'(xfer_pc.size() >= n), 32'd1);
  endtask

  task automatic wait_accepts(input int n, input string name);
    int k = 0;
    while (acc_addr.size() < n && k < 200) begin
      tick(1);
      k++;
    end
    chk({name, "_acc_timeout"}, 32'(acc_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!o_if_valid && k < 200) begin
      tick(1);
      k++;
    end
    chk({name, "_valid_timeout"}, 32'(o_if_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_pc, hold_inst;
    int na;

    // reset values and steady fetch at full rate
    tick(2);
    chk("rst_req", 32'(inst_sram_req), 32'd0);
    chk("rst_valid", 32'(o_if_valid), 32'd0);
    chk("rst_if_pc", if_pc, RST_PC);
    chk("rst_if_inst", if_inst, 32'd0);
    rst = 1'b0;
    chk("boot_req", 32'(inst_sram_req), 32'd0);
    inst_sram_addr_ok = 1'b1;
    i_if_ready = 1'b1;
    wait_xfers(3, "steady");
    chk("steady_x0", get_xfer(0), 32'h1c000000);
    chk("steady_x1", get_xfer(1), 32'h1c000004);
    chk("steady_x2", get_xfer(2), 32'h1c000008);
    chk("steady_gap1", 32'(xfer_gap(1)), 32'd3);
    chk("steady_gap2", 32'(xfer_gap(2)), 32'd3);
    chk("steady_a2", get_acc(2), 32'h1c000008);
    chk("steady_agap", 32'(acc_gap(1)), 32'd3);

    // back-pressure in HOLD
    apply_reset();
    inst_sram_addr_ok = 1'b1;
    wait_valid("bp");
    hold_pc = if_pc;
    hold_inst = if_inst;
    na = acc_addr.size();
    chk("bp_pc", hold_pc, 32'h1c000000);
    tick(5);
    chk("bp_valid_held", 32'(o_if_valid), 32'd1);
    chk("bp_pc_stable", if_pc, hold_pc);
    chk("bp_inst_stable", if_inst, hold_inst);
    chk("bp_no_new_req", 32'(acc_addr.size()), 32'(na));
    i_if_ready = 1'b1;
    wait_accepts(2, "bp");
    chk("bp_next_addr", get_acc(1), 32'h1c000004);

    // redirect in WAIT before data returns
    apply_reset();
    mem_lat = 3;
    inst_sram_addr_ok = 1'b1;
    i_if_ready = 1'b1;
    wait_accepts(1, "wait_br");
    mem_lat = 1;
    pulse_br(32'h1c000100);
    wait_xfers(1, "wait_br");
    chk("wait_br_a0", get_acc(0), 32'h1c000000);
    chk("wait_br_a1", get_acc(1), 32'h1c000100);
    chk("wait_br_x0", get_xfer(0), 32'h1c000100);

    // redirect coincident with addr_ok
    apply_reset();
    i_if_ready = 1'b1;
    tick(1);
    chk("coin_req", 32'(inst_sram_req), 32'd1);
    inst_sram_addr_ok = 1'b1;
    pulse_br(32'h1c000100);
    wait_xfers(1, "coin");
    chk("coin_a0", get_acc(0), 32'h1c000000);
    chk("coin_a1", get_acc(1), 32'h1c000100);
    chk("coin_x0", get_xfer(0), 32'h1c000100);

    // redirect in REQ while addr_ok is held low
    apply_reset();
    i_if_ready = 1'b1;
    tick(1);
    pulse_br(32'h1c000100);
    for (int i = 0; i < 3; i++) begin
      chk("reqbr_req", 32'(inst_sram_req), 32'd1);
      chk("reqbr_addr", inst_sram_addr, 32'h1c000100);
      if (i < 2) tick(1);
    end
    inst_sram_addr_ok = 1'b1;
    wait_xfers(1, "reqbr");
    chk("reqbr_a0", get_acc(0), 32'h1c000100);
    chk("reqbr_x0", get_xfer(0), 32'h1c000100);

    // back-to-back redirects in WAIT: latest target wins
    apply_reset();
    mem_lat = 4;
    inst_sram_addr_ok = 1'b1;
    i_if_ready = 1'b1;
    wait_accepts(1, "dbl");
    mem_lat = 1;
    pulse_br(32'h1c000200);
    pulse_br(32'h1c000300);
    wait_xfers(1, "dbl");
    chk("dbl_a1", get_acc(1), 32'h1c000300);
    chk("dbl_x0", get_xfer(0), 32'h1c000300);

    // redirect in HOLD wins over a same-cycle ready
    apply_reset();
    inst_sram_addr_ok = 1'b1;
    wait_valid("hold_br");
    i_if_ready = 1'b1;
    pulse_br(32'h1c000400);
    chk("hold_br_valid_drop", 32'(o_if_valid), 32'd0);
    wait_xfers(2, "hold_br");
    chk("hold_br_x0", get_xfer(0), 32'h1c000000);
    chk("hold_br_x1", get_xfer(1), 32'h1c000400);

    // asynchronous reset while an access is outstanding
    apply_reset();
    mem_lat = 3;
    i_if_ready = 1'b1;
    tick(1);
    pulse_br(32'h1c000300);
    inst_sram_addr_ok = 1'b1;
    wait_xfers(1, "rstw");
    wait_accepts(2, "rstw");
    chk("rstw_a1", get_acc(1), 32'h1c000304);
    rst = 1'b1;
    #1;
    chk("rstw_req", 32'(inst_sram_req), 32'd0);
    chk("rstw_valid", 32'(o_if_valid), 32'd0);
    chk("rstw_if_pc", if_pc, RST_PC);
    chk("rstw_if_inst", if_inst, 32'd0);
    tick(1);
    rst = 1'b0;
    mem_lat = 1;
    chk("rstw_boot_req", 32'(inst_sram_req), 32'd0);
    tick(1);
    chk("rstw_req_after", 32'(inst_sram_req), 32'd1);
    chk("rstw_addr_after", inst_sram_addr, RST_PC);
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
